memory_stage: RTL and testbench

Fourth pipeline stage of the rvga core: consumes the execute stage's registered control word, ALU result (effective address) and store data, and issues loads/stores on a valid/ready data-memory port. Formats store byte lanes, extracts and sign-extends load data, supplies the forwarding value back to execute, and stalls the pipeline until each memory transaction completes.

---
 rtl/memory_stage.sv | 113 +++++++++++
 tb/tb_memory_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: rvga load/store stage with valid/ready data-memory port and stall generation
package rvga_pkg;
  typedef logic [31:0] rvga_word;
  typedef struct packed {
    logic [2:0] funct3;
    logic       dmem_r_v;
    logic       dmem_w_v;
    logic       rf_w_v;
    logic [4:0] rd_addr;
  } rvga_cword;
  typedef struct packed {
    rvga_word pc;
    rvga_word alu_result;
    rvga_word ld_result;
  } rvga_dword;
endpackage

module memory_stage
  import rvga_pkg::*;
#(
  parameter int data_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    stall_v_i,
  input  rvga_cword               cword_i,
  input  rvga_dword               dword_i,
  input  logic [data_width_p-1:0] alu_result_i,
  input  logic [data_width_p-1:0] st_data_i,
  output rvga_cword               cword_o,
  output rvga_dword               dword_o,
  output logic [data_width_p-1:0] rd_data_o,
  output logic                    stall_v_o,
  output logic                    misalign_v_o,
  output logic                    dmem_v_o,
  output logic                    dmem_w_o,
  output logic [data_width_p-1:0] dmem_addr_o,
  output logic [data_width_p-1:0] dmem_wdata_o,
  output logic [3:0]              dmem_wmask_o,
  input  logic                    dmem_ready_i,
  input  logic                    dmem_rdata_v_i,
  input  logic [data_width_p-1:0] dmem_rdata_i
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  state_e                  state_q, state_d;
  rvga_cword               cword_q;
  rvga_dword               dword_q, dword_d;
  logic [data_width_p-1:0] st_q, s, ld_ext;
  logic [1:0]              a;
  logic [2:0]              f3;
  logic                    capture, unused_dword;
  function automatic logic aligned(input logic [2:0] fn, input logic [1:0] lo);
    return (fn[1:0] == 2'b00) | ((fn[1:0] == 2'b01) & ~lo[0]) | (lo == 2'b00);
  endfunction
  // execute's alu/ld fields are superseded by this stage's own values
  assign unused_dword = ^{dword_i.alu_result, dword_i.ld_result};
  assign stall_v_o = state_q != IDLE;
  assign capture = ~stall_v_i & ~stall_v_o;
  assign a = dword_q.alu_result[1:0];
  assign f3 = cword_q.funct3;
  assign s = dmem_rdata_i >> {a, 3'b000};
  assign ld_ext = f3 == 3'b000 ? {{24{s[7]}}, s[7:0]} :
                  f3 == 3'b001 ? {{16{s[15]}}, s[15:0]} :
                  f3 == 3'b100 ? {24'b0, s[7:0]} :
                  f3 == 3'b101 ? {16'b0, s[15:0]} : s;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = capture && (cword_i.dmem_r_v || cword_i.dmem_w_v) &&
                         aligned(cword_i.funct3, alu_result_i[1:0]) ? REQ : IDLE;
      REQ:     state_d = !dmem_ready_i ? REQ : cword_q.dmem_w_v ? IDLE : RESP;
      RESP:    state_d = dmem_rdata_v_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    dword_d = dword_q;
    if (capture) begin
      dword_d = dword_i;
      dword_d.alu_result = alu_result_i;
      dword_d.ld_result = '0;
    end else if (state_q == RESP && dmem_rdata_v_i) begin
      dword_d.ld_result = ld_ext;
    end
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cword_q <= '0;
      dword_q <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      dword_q <= dword_d;
      if (capture) begin
        cword_q <= cword_i;
        st_q    <= st_data_i;
      end
    end
  end
  assign cword_o = stall_v_o ? '0 : cword_q;
  assign dword_o = dword_q;
  assign rd_data_o = cword_q.dmem_r_v ? dword_q.ld_result : dword_q.alu_result;
  assign misalign_v_o = (cword_q.dmem_r_v | cword_q.dmem_w_v) & ~aligned(f3, a);
  assign dmem_v_o = state_q == REQ;
  assign dmem_w_o = cword_q.dmem_w_v;
  assign dmem_addr_o = {dword_q.alu_result[31:2], 2'b00};
  assign dmem_wdata_o = f3[1:0] == 2'b00 ? {4{st_q[7:0]}} :
                        f3[1:0] == 2'b01 ? {2{st_q[15:0]}} : st_q;
  assign dmem_wmask_o = !cword_q.dmem_w_v ? 4'b0000 :
                        f3[1:0] == 2'b00 ? 4'b0001 << a :
                        f3[1:0] == 2'b01 ? 4'b0011 << a : 4'b1111;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: scoreboard bench for memory_stage with a modelled valid/ready data memory
module tb_memory_stage;
  import rvga_pkg::*;
  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } req_t;
  logic        clk_i = 1'b0;
  logic        rst_i, stall_v_i;
  rvga_cword   cword_i, cword_o;
  rvga_dword   dword_i, dword_o;
  logic [31:0] alu_result_i, st_data_i, rd_data_o;
  logic        stall_v_o, misalign_v_o, dmem_v_o, dmem_w_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_wmask_o;
  logic        dmem_ready_i, dmem_rdata_v_i;
  req_t        req_q[$];
  int          n_cmp = 0, n_err = 0;
  int          ready_dly = 0;
  logic [31:0] resp_data = '0;

  memory_stage #(.data_width_p(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_v_i(stall_v_i),
    .cword_i(cword_i), .dword_i(dword_i), .alu_result_i(alu_result_i), .st_data_i(st_data_i),
    .cword_o(cword_o), .dword_o(dword_o), .rd_data_o(rd_data_o),
    .stall_v_o(stall_v_o), .misalign_v_o(misalign_v_o),
    .dmem_v_o(dmem_v_o), .dmem_w_o(dmem_w_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_wmask_o(dmem_wmask_o),
    .dmem_ready_i(dmem_ready_i), .dmem_rdata_v_i(dmem_rdata_v_i), .dmem_rdata_i(dmem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic rvga_cword mk_cw(input logic [2:0] f3, input logic r, input logic w);
    mk_cw = '0;
    mk_cw.funct3 = f3;
    mk_cw.dmem_r_v = r;
    mk_cw.dmem_w_v = w;
    mk_cw.rf_w_v = ~w;
    mk_cw.rd_addr = 5'd7;
  endfunction

  // memory model: pops expected requests on acceptance, answers loads one cycle later
  initial begin
    int   rcnt;
    logic acc_ld;
    req_t r;
    rcnt = 0;
    dmem_ready_i = 1'b0;
    dmem_rdata_v_i = 1'b0;
    dmem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      acc_ld = 1'b0;
      if (dmem_v_o && dmem_ready_i) begin
        if (req_q.size() == 0) chk("unexp_req", 32'(dmem_v_o), 32'd0);
        else begin
          r = req_q.pop_front();
          chk("req_w", 32'(dmem_w_o), 32'(r.w));
          chk("req_addr", dmem_addr_o, r.addr);
          chk("req_mask", 32'(dmem_wmask_o), 32'(r.mask));
          if (r.w) chk("req_wdata", dmem_wdata_o, r.wdata);
          acc_ld = !dmem_w_o;
        end
      end
      @(posedge clk_i);
      #2;
      dmem_rdata_v_i = acc_ld;
      dmem_rdata_i = acc_ld ? resp_data : 32'h0;
      if (dmem_v_o) begin
        dmem_ready_i = rcnt >= ready_dly;
        rcnt++;
      end else begin
        dmem_ready_i = 1'b0;
        rcnt = 0;
      end
    end
  end

  task automatic op(input string tag, input logic [2:0] f3, input logic r, input logic w,
                    input logic [31:0] addr, input logic [31:0] st, input int rdly,
                    input logic [31:0] rdata, input int exp_stall, input logic [31:0] exp_rd,
                    input logic [31:0] exp_wdata, input logic [3:0] exp_mask);
    rvga_cword cw;
    int        n;
    cw = mk_cw(f3, r, w);
    @(posedge clk_i);
    #1;
    stall_v_i = 1'b0;
    cword_i = cw;
    dword_i = '{pc: 32'h100, alu_result: 32'hFFFF_FFFF, ld_result: 32'hFFFF_FFFF};
    alu_result_i = addr;
    st_data_i = st;
    ready_dly = rdly;
    resp_data = rdata;
    if (exp_stall != 0)
      req_q.push_back('{w: w, addr: {addr[31:2], 2'b00}, wdata: exp_wdata, mask: exp_mask});
    @(posedge clk_i);
    #1;
    cword_i = '0;
    alu_result_i = '0;
    st_data_i = '0;
    n = 0;
    @(negedge clk_i);
    while (stall_v_o && n < 50) begin
      n++;
      @(negedge clk_i);
    end
    chk({tag, "_stall"}, n, exp_stall);
    chk({tag, "_rd"}, rd_data_o, exp_rd);
    chk({tag, "_cword"}, 32'(cword_o), 32'(cw));
    chk({tag, "_alu"}, dword_o.alu_result, addr);
    chk({tag, "_ld"}, dword_o.ld_result, r ? exp_rd : 32'h0);
    chk({tag, "_pc"}, dword_o.pc, 32'h100);
    chk({tag, "_mis"}, 32'(misalign_v_o), 32'((r | w) && exp_stall == 0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    stall_v_i = 1'b0;
    cword_i = '0;
    dword_i = '0;
    alu_result_i = '0;
    st_data_i = '0;
    #2 rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_stall", 32'(stall_v_o), 32'd0);
    chk("rst_dmem_v", 32'(dmem_v_o), 32'd0);
    chk("rst_cword", 32'(cword_o), 32'd0);
    chk("rst_rd", rd_data_o, 32'd0);
    chk("rst_mask", 32'(dmem_wmask_o), 32'd0);
    rst_i = 1'b1;
    // abort a load stuck in REQ with an asynchronous reset
    cword_i = mk_cw(3'b010, 1'b1, 1'b0);
    alu_result_i = 32'h5000;
    ready_dly = 30;
    @(posedge clk_i);
    #1 cword_i = '0;
    @(negedge clk_i);
    chk("mid_req_v", 32'(dmem_v_o), 32'd1);
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk("arst_dmem_v", 32'(dmem_v_o), 32'd0);
    chk("arst_stall", 32'(stall_v_o), 32'd0);
    chk("arst_cword", 32'(cword_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_idle", 32'(stall_v_o), 32'd0);
    op("sb",  3'b000, 1'b0, 1'b1, 32'h1003, 32'h0000_00AB, 0, 32'h0, 1, 32'h1003, 32'hABAB_ABAB, 4'b1000);
    op("sh",  3'b001, 1'b0, 1'b1, 32'h1002, 32'h1234_ABCD, 2, 32'h0, 3, 32'h1002, 32'hABCD_ABCD, 4'b1100);
    op("lh",  3'b001, 1'b1, 1'b0, 32'h2002, 32'h0, 3, 32'h8001_1234, 5, 32'hFFFF_8001, 32'h0, 4'b0000);
    op("lbu", 3'b100, 1'b1, 1'b0, 32'h2001, 32'h0, 0, 32'h0000_F500, 2, 32'h0000_00F5, 32'h0, 4'b0000);
    op("lb",  3'b000, 1'b1, 1'b0, 32'h2001, 32'h0, 0, 32'h0000_F500, 2, 32'hFFFF_FFF5, 32'h0, 4'b0000);
    op("lhu", 3'b101, 1'b1, 1'b0, 32'h2000, 32'h0, 0, 32'h1234_F00F, 2, 32'h0000_F00F, 32'h0, 4'b0000);
    op("lw_mis", 3'b010, 1'b1, 1'b0, 32'h3002, 32'h0, 0, 32'hCAFE_F00D, 0, 32'h0, 32'h0, 4'b0000);
    chk("lw_mis_dmem_v", 32'(dmem_v_o), 32'd0);
    op("add", 3'b000, 1'b0, 1'b0, 32'h55, 32'h0, 0, 32'h0, 0, 32'h55, 32'h0, 4'b0000);
    stall_v_i = 1'b1;
    cword_i = mk_cw(3'b010, 1'b0, 1'b1);
    alu_result_i = 32'h4000;
    st_data_i = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk_i);
    chk("blk_stall", 32'(stall_v_o), 32'd0);
    chk("blk_dmem_v", 32'(dmem_v_o), 32'd0);
    chk("blk_cword", 32'(cword_o), 32'(mk_cw(3'b000, 1'b0, 1'b0)));
    chk("blk_rd", rd_data_o, 32'h55);
    op("sw",  3'b010, 1'b0, 1'b1, 32'h4000, 32'hDEAD_BEEF, 0, 32'h0, 1, 32'h4000, 32'hDEAD_BEEF, 4'b1111);
    op("lw",  3'b010, 1'b1, 1'b0, 32'h4000, 32'h0, 1, 32'h1357_9BDF, 3, 32'h1357_9BDF, 32'h0, 4'b0000);
    repeat (2) @(negedge clk_i);
    chk("req_q_empty", req_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
